// File: rtl/smvm_job_sequencer.sv
// smvm_job_sequencer: fetches one sparse matrix-vector job from a synchronous-read buffer,
// replays it gap-free into the byte-serial SMVM datapath, and forwards its results.
module smvm_job_sequencer #(
  parameter int unsigned K          = 4,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_start,
  input  logic [8:0]        job_rows,
  input  logic [8:0]        job_cols,
  input  logic [15:0]       job_groups,
  input  logic [ADDR_W-1:0] vec_base,
  input  logic [ADDR_W-1:0] mat_base,
  output logic              job_busy,
  output logic              job_done,
  output logic              job_err,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [17:0]       mem_rdata,
  output logic [7:0]        smvm_val,
  output logic              smvm_ipv,
  output logic              smvm_in_valid,
  input  logic              smvm_out_valid,
  input  logic [12:0]       smvm_data,
  output logic              res_valid,
  output logic [12:0]       res_data,
  output logic [8:0]        res_idx
);

  // Entry count width: groups times K
  localparam int unsigned NW = 16 + $clog2(K);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRows  = 3'd1;
  localparam logic [2:0] StCols  = 3'd2;
  localparam logic [2:0] StVec   = 3'd3;
  localparam logic [2:0] StMat   = 3'd4;
  localparam logic [2:0] StFlush = 3'd5;
  localparam logic [2:0] StWait  = 3'd6;
  localparam logic [2:0] StDone  = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [8:0]    rows_q, rows_d;
  logic [8:0]    cols_q, cols_d;
  logic [NW-1:0] total_q, total_d;
  logic [8:0]    vcnt_q, vcnt_d;
  logic [NW-1:0] ecnt_q, ecnt_d;
  logic          emit_idx_q, emit_idx_d;
  logic [8:0]    hold_col_q, hold_col_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic          in_valid_q, in_valid_d;
  logic [7:0]    val_q, val_d;
  logic          ipv_q, ipv_d;
  logic          accept;
  logic          reject;
  logic [NW-1:0] ent_total;

  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [8:0]        rd_vec_q;
  logic [NW-1:0]     rd_ent_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              rd_gap_q;

  logic        res_valid_q;
  logic [12:0] res_data_q;
  logic [8:0]  res_idx_q;
  logic [8:0]  res_cnt_q;
  logic        collect;

  assign ent_total = NW'(job_groups) * NW'(K);
  assign reject    = (job_rows == 9'd0) || (job_cols == 9'd0) || (job_groups == 16'd0);

  // Next-state and datapath stream: the value registered here is what the datapath sees next cycle
  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    total_d    = total_q;
    vcnt_d     = vcnt_q;
    ecnt_d     = ecnt_q;
    emit_idx_d = emit_idx_q;
    hold_col_d = hold_col_q;
    wait_d     = wait_q;
    err_d      = err_q;
    in_valid_d = 1'b0;
    val_d      = 8'd0;
    ipv_d      = 1'b0;
    accept     = 1'b0;
    case (state_q)
      StIdle: begin
        if (job_start) begin
          rows_d  = job_rows;
          cols_d  = job_cols;
          total_d = ent_total;
          if (reject) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            accept     = 1'b1;
            state_d    = StRows;
            err_d      = 1'b0;
            in_valid_d = 1'b1;
            val_d      = job_rows[8:1];
            ipv_d      = job_rows[0];
          end
        end
      end
      StRows: begin
        state_d    = StCols;
        in_valid_d = 1'b1;
        val_d      = cols_q[8:1];
        ipv_d      = cols_q[0];
      end
      StCols: begin
        state_d    = StVec;
        in_valid_d = 1'b1;
        val_d      = mem_rdata[7:0];
        vcnt_d     = cols_q - 9'd1;
      end
      StVec: begin
        in_valid_d = 1'b1;
        if (vcnt_q != 9'd0) begin
          val_d  = mem_rdata[7:0];
          vcnt_d = vcnt_q - 9'd1;
        end else begin
          // First entry VAL; its column is held for the following IDX cycle
          state_d    = StMat;
          val_d      = mem_rdata[17:10];
          ipv_d      = mem_rdata[9];
          hold_col_d = mem_rdata[8:0];
          ecnt_d     = total_q - NW'(1);
          emit_idx_d = 1'b1;
        end
      end
      StMat: begin
        if (emit_idx_q) begin
          in_valid_d = 1'b1;
          val_d      = hold_col_q[8:1];
          ipv_d      = hold_col_q[0];
          emit_idx_d = 1'b0;
        end else if (ecnt_q == '0) begin
          state_d = StFlush;
        end else begin
          in_valid_d = 1'b1;
          val_d      = mem_rdata[17:10];
          ipv_d      = mem_rdata[9];
          hold_col_d = mem_rdata[8:0];
          ecnt_d     = ecnt_q - NW'(1);
          emit_idx_d = 1'b1;
        end
      end
      StFlush: begin
        state_d = StWait;
        wait_d  = TW'(1);
      end
      StWait: begin
        // wait_q counts cycles since FLUSH; leaving now puts DONE at FLUSH + wait_q + 1
        if ((res_cnt_q == rows_q) && (32'(wait_q) + 32'd1 >= GAP_CYCLES)) begin
          state_d = StDone;
          err_d   = 1'b0;
        end else if (wait_q == TW'(TIMEOUT)) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        wait_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and registered datapath stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rows_q     <= '0;
      cols_q     <= '0;
      total_q    <= '0;
      vcnt_q     <= '0;
      ecnt_q     <= '0;
      emit_idx_q <= 1'b0;
      hold_col_q <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      in_valid_q <= 1'b0;
      val_q      <= '0;
      ipv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      total_q    <= total_d;
      vcnt_q     <= vcnt_d;
      ecnt_q     <= ecnt_d;
      emit_idx_q <= emit_idx_d;
      hold_col_q <= hold_col_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      in_valid_q <= in_valid_d;
      val_q      <= val_d;
      ipv_q      <= ipv_d;
    end
  end

  // Read engine: runs two cycles ahead of the stream; vector reads back-to-back, entries every other
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      rd_vec_q   <= '0;
      rd_ent_q   <= '0;
      rd_ptr_q   <= '0;
      rd_gap_q   <= 1'b0;
    end else if (accept) begin
      mem_rd_q   <= 1'b1;
      mem_addr_q <= vec_base;
      rd_vec_q   <= job_cols - 9'd1;
      rd_ent_q   <= ent_total;
      rd_ptr_q   <= mat_base;
      rd_gap_q   <= 1'b0;
    end else if (rd_vec_q != 9'd0) begin
      mem_rd_q   <= 1'b1;
      mem_addr_q <= mem_addr_q + ADDR_W'(1);
      rd_vec_q   <= rd_vec_q - 9'd1;
    end else if ((rd_ent_q != '0) && !rd_gap_q) begin
      mem_rd_q   <= 1'b1;
      mem_addr_q <= rd_ptr_q;
      rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
      rd_ent_q   <= rd_ent_q - NW'(1);
      rd_gap_q   <= 1'b1;
    end else begin
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      rd_gap_q   <= 1'b0;
    end
  end

  assign collect = (state_q == StMat) || (state_q == StFlush) || (state_q == StWait);

  // Result forwarding: tag each result with its row index, drop anything beyond rows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      res_cnt_q   <= '0;
    end else if (accept) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      res_cnt_q   <= '0;
    end else if (collect && smvm_out_valid && (res_cnt_q < rows_q)) begin
      res_valid_q <= 1'b1;
      res_data_q  <= smvm_data;
      res_idx_q   <= res_cnt_q;
      res_cnt_q   <= res_cnt_q + 9'd1;
    end else begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
    end
  end

  assign job_busy      = (state_q != StIdle) && (state_q != StDone);
  assign job_done      = (state_q == StDone);
  assign job_err       = (state_q == StDone) && err_q;
  assign mem_rd        = mem_rd_q;
  assign mem_addr      = mem_addr_q;
  assign smvm_val      = val_q;
  assign smvm_ipv      = ipv_q;
  assign smvm_in_valid = in_valid_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_idx       = res_idx_q;

endmodule

// File: tb/tb_smvm_job_sequencer.sv
// Directed bench for smvm_job_sequencer with a buffer model and a scripted datapath stub.
module tb_smvm_job_sequencer;

  typedef struct {
    int rows;
    int cols;
    int groups;
    int stub_n;
    int exp_err;
    int exp_done;
    int exp_beats;
    int exp_rd;
    int exp_res;
  } vec_t;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_start = 1'b0;
  logic [8:0]  job_rows = '0;
  logic [8:0]  job_cols = '0;
  logic [15:0] job_groups = '0;
  logic [15:0] vec_base = 16'd16;
  logic [15:0] mat_base = 16'd32;
  logic        job_busy, job_done, job_err, mem_rd;
  logic [15:0] mem_addr;
  logic [17:0] mem_rdata = '0;
  logic [7:0]  smvm_val;
  logic        smvm_ipv, smvm_in_valid;
  logic        smvm_out_valid = 1'b0;
  logic [12:0] smvm_data = '0;
  logic        res_valid;
  logic [12:0] res_data;
  logic [8:0]  res_idx;
  logic [52:0] all_out;

  logic [17:0] mem [0:255];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   flush_cyc = -1;
  int   stub_n = 0;
  logic iv_prev = 1'b0;
  int   stub_data [3] = '{29, 46, 77};
  ev_t  iv_q[$], rd_q[$], res_q[$], done_q[$];

  smvm_job_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .job_start      (job_start),
    .job_rows       (job_rows),
    .job_cols       (job_cols),
    .job_groups     (job_groups),
    .vec_base       (vec_base),
    .mat_base       (mat_base),
    .job_busy       (job_busy),
    .job_done       (job_done),
    .job_err        (job_err),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .smvm_val       (smvm_val),
    .smvm_ipv       (smvm_ipv),
    .smvm_in_valid  (smvm_in_valid),
    .smvm_out_valid (smvm_out_valid),
    .smvm_data      (smvm_data),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .res_idx        (res_idx)
  );

  assign all_out = {job_busy, job_done, job_err, mem_rd, mem_addr, smvm_val, smvm_ipv,
                    smvm_in_valid, res_valid, res_data, res_idx};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read buffer
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];

  // Monitor on the falling edge, plus datapath stub answering at FLUSH+1, +3, +5
  always @(negedge clk) begin
    if (smvm_in_valid) iv_q.push_back('{cyc, int'({smvm_val, smvm_ipv}), 0});
    if (mem_rd) rd_q.push_back('{cyc, int'(mem_addr), 0});
    if (res_valid) res_q.push_back('{cyc, int'(res_data), int'(res_idx)});
    if (job_done) done_q.push_back('{cyc, int'(job_err), 0});
    if (iv_prev && !smvm_in_valid && job_busy) flush_cyc = cyc;
    iv_prev = smvm_in_valid;
    smvm_out_valid = 1'b0;
    smvm_data = '0;
    for (int k = 0; k < stub_n; k++) begin
      if (flush_cyc >= 0 && cyc == flush_cyc + 1 + 2 * k) begin
        smvm_out_valid = 1'b1;
        smvm_data = 13'(stub_data[k]);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_job(input int rows, input int cols, input int groups, input int sn,
                         input int pulse_at, output int t);
    iv_q.delete(); rd_q.delete(); res_q.delete(); done_q.delete();
    flush_cyc = -1;
    stub_n = sn;
    @(negedge clk);
    job_rows = 9'(rows);
    job_cols = 9'(cols);
    job_groups = 16'(groups);
    job_start = 1'b1;
    t = cyc;
    for (int i = 0; i < 6000 && done_q.size() == 0; i++) begin
      @(negedge clk);
      job_start = (pulse_at != 0) && (cyc == t + pulse_at);
      if (job_start) job_rows = 9'd0;
    end
    job_start = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_job(input int i, input vec_t v, input int t);
    int f;
    f = t + 3 + v.cols + 8 * v.groups;
    check($sformatf("job%0d_done_count", i), done_q.size(), 1);
    if (done_q.size() > 0) begin
      check($sformatf("job%0d_done_cycle", i), done_q[0].cyc - t, v.exp_done);
      check($sformatf("job%0d_err", i), done_q[0].a, v.exp_err);
    end
    check($sformatf("job%0d_in_valid_beats", i), iv_q.size(), v.exp_beats);
    check($sformatf("job%0d_mem_rd_count", i), rd_q.size(), v.exp_rd);
    check($sformatf("job%0d_res_count", i), res_q.size(), v.exp_res);
    if (v.exp_beats > 0 && iv_q.size() > 0)
      check($sformatf("job%0d_last_beat", i), iv_q[iv_q.size() - 1].cyc - t, v.exp_beats);
    for (int k = 0; k < res_q.size() && k < v.exp_res; k++) begin
      check($sformatf("job%0d_res%0d_idx", i, k), res_q[k].b, k);
      check($sformatf("job%0d_res%0d_data", i, k), res_q[k].a, stub_data[k]);
      check($sformatf("job%0d_res%0d_cycle", i, k), res_q[k].cyc, f + 2 + 2 * k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [8];
    int   exp_stream [14];
    int   t;

    // rows, cols, groups, stub results, err, done offset, beats, reads, forwarded results
    tbl[0] = '{2, 4, 1, 2, 0, 23, 14, 8, 2};
    tbl[1] = '{1, 3, 2, 1, 0, 30, 21, 11, 1};
    tbl[2] = '{2, 0, 1, 2, 1, 1, 0, 0, 0};
    tbl[3] = '{0, 4, 1, 2, 1, 1, 0, 0, 0};
    tbl[4] = '{2, 4, 0, 2, 1, 1, 0, 0, 0};
    tbl[5] = '{3, 1, 1, 3, 0, 20, 11, 5, 3};
    tbl[6] = '{2, 2, 1, 3, 0, 21, 12, 6, 2};
    tbl[7] = '{1, 1, 1, 1, 0, 20, 11, 5, 1};
    // {val, ipv} as seen by the datapath for the basic job
    exp_stream = '{9'h002, 9'h004, 9'h002, 9'h004, 9'h006, 9'h008, 9'h00B, 9'h000,
                   9'h00C, 9'h003, 9'h00F, 9'h001, 9'h010, 9'h002};

    for (int i = 0; i < 256; i++) mem[i] = 18'(i * 37 + 5);
    mem[16] = 18'd1;
    mem[17] = 18'd2;
    mem[18] = 18'd3;
    mem[19] = 18'd4;
    mem[32] = {8'd5, 1'b1, 9'd0};
    mem[33] = {8'd6, 1'b0, 9'd3};
    mem[34] = {8'd7, 1'b1, 9'd1};
    mem[35] = {8'd8, 1'b0, 9'd2};

    repeat (3) @(negedge clk);
    check("reset_outputs", longint'(all_out), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", longint'(all_out), 0);

    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i].rows, tbl[i].cols, tbl[i].groups, tbl[i].stub_n, 0, t);
      check_job(i, tbl[i], t);
    end

    // Basic job: exact datapath stream
    run_job(2, 4, 1, 2, 0, t);
    check("basic_beats", iv_q.size(), 14);
    for (int k = 0; k < 14 && k < iv_q.size(); k++) begin
      check($sformatf("basic_beat%0d_val", k), iv_q[k].a, exp_stream[k]);
      check($sformatf("basic_beat%0d_cycle", k), iv_q[k].cyc - t, k + 1);
    end

    // Read timing and addresses
    run_job(1, 3, 2, 1, 0, t);
    check("rd_count", rd_q.size(), 11);
    for (int k = 0; k < 11 && k < rd_q.size(); k++) begin
      check($sformatf("rd%0d_cycle", k), rd_q[k].cyc - t, (k < 3) ? (k + 1) : (4 + 2 * (k - 3)));
      check($sformatf("rd%0d_addr", k), rd_q[k].a, (k < 3) ? (16 + k) : (32 + k - 3));
    end
    check("rd_flush_cycle", flush_cyc - t, 22);

    // job_start (a would-be reject) pulsed during VEC is ignored
    run_job(2, 4, 1, 2, 4, t);
    check("busy_done_count", done_q.size(), 1);
    if (done_q.size() > 0) begin
      check("busy_done_cycle", done_q[0].cyc - t, 23);
      check("busy_err", done_q[0].a, 0);
    end
    check("busy_res_count", res_q.size(), 2);

    // One of two results: timeout after exactly 4096 WAIT cycles
    run_job(2, 1, 1, 1, 0, t);
    check("timeout_done_count", done_q.size(), 1);
    if (done_q.size() > 0) begin
      check("timeout_done_cycle", done_q[0].cyc - t, 12 + 4096 + 1);
      check("timeout_err", done_q[0].a, 1);
    end
    check("timeout_res_count", res_q.size(), 1);

    // Reset in the middle of MAT
    iv_q.delete(); rd_q.delete(); res_q.delete(); done_q.delete();
    flush_cyc = -1;
    stub_n = 2;
    @(negedge clk);
    job_rows = 9'd2;
    job_cols = 9'd4;
    job_groups = 16'd2;
    job_start = 1'b1;
    t = cyc;
    @(negedge clk);
    job_start = 1'b0;
    while (cyc < t + 10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midreset_outputs", longint'(all_out), 0);
    repeat (4) @(negedge clk);
    check("midreset_no_done", done_q.size(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(2, 4, 1, 2, 0, t);
    check("after_reset_done_count", done_q.size(), 1);
    if (done_q.size() > 0) begin
      check("after_reset_done_cycle", done_q[0].cyc - t, 23);
      check("after_reset_err", done_q[0].a, 0);
    end
    check("after_reset_beats", iv_q.size(), 14);
    check("after_reset_res_count", res_q.size(), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
